ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have ports: clk in 1, system clock; rst in 1, synchronous active-high reset.
REQ-002 SHALL have rdy_in in 1: high = run, low = stall.
REQ-003 SHALL have instruction port: if_req in 1; if_addr in 32; flush in 1; if_ack out 1; if_data out 32.
REQ-004 SHALL have data port: d_req in 1; d_we in 1; d_size in 2 (0 byte, 1 half, 2/3 word); d_addr in 32; d_wdata in 32; d_ack out 1; d_rdata out 32.
REQ-005 SHALL have RAM port: mem_din in 8; mem_dout out 8; mem_a out 32; mem_wr out 1 (1 = write).
REQ-006 SHALL have busy out 1: high when the state is not IDLE.
REQ-007 Parameter STARVE_MAX, default 4: maximum number of consecutive data grants while if_req is pending.

Function
REQ-008 SHALL implement states IDLE, RD, WR, DONE, and share one byte-wide RAM between the IF and data requesters.
REQ-009 Grant SHALL be evaluated only in IDLE with rdy_in high.
- d_req wins if starve_cnt < STARVE_MAX or if_req is low.
- Otherwise IF wins if if_req is high and flush is low.
REQ-010 starve_cnt SHALL increment, saturating at STARVE_MAX, on each data grant while if_req is high, and SHALL clear on IF grant.
REQ-011 Grant SHALL latch addr, n (IF = 4, d_size 0/1/2/3 -> 1/2/4/4), we, wdata, and owner. Requesters SHALL hold inputs stable until ack.
REQ-012 Read, with grant sampled at the edge ending cycle G:
- mem_a = addr+k, mem_wr = 0 in cycles G+1..G+n.
- Byte k SHALL be captured from mem_din at the edge ending cycle G+k+2, into bits [8k+7:8k] (little-endian).
- DONE SHALL occur in cycle G+n+2. Word read ack = 6 cycles after G.
REQ-013 Write: mem_wr = 1, mem_a = addr+k, mem_dout = wdata[8k+7:8k] in cycles G+1..G+n. DONE SHALL occur in cycle G+n+1.
REQ-014 DONE SHALL last exactly one cycle:
- Owner's ack is high and rdata is valid that cycle only.
- No grant is made in DONE.
- Next state is IDLE.
REQ-015 d_rdata SHALL be zero-extended for byte and half reads. d_rdata SHALL be 0 for writes.
REQ-016 Address increment SHALL be full 32-bit modulo 2^32 (0xFFFFFFFF+1 = 0). No alignment check.
REQ-017 Outside RD/WR, mem_a SHALL be 0, mem_wr 0, mem_dout 0.
REQ-018 On a rdy_in-low cycle:
- No state, counter or issue advance.
- mem_wr SHALL be forced 0; mem_a is held.
- A byte presented in the previous cycle SHALL still be captured.
- On resume, issue SHALL continue with the next byte, and the write byte pending at the stall SHALL be re-driven with mem_wr = 1.
REQ-019 flush during an IF transaction: the transaction SHALL complete on the RAM bus, but if_ack SHALL be suppressed in its DONE cycle. flush SHALL have no effect on data transactions.
REQ-020 Acks SHALL be mutually exclusive. At most one transaction SHALL be outstanding.
REQ-021 All outputs SHALL be registered, except busy, which is decoded from the state register.

Reset
REQ-022 rst SHALL force, at the next clk edge and regardless of rdy_in or state:
- state = IDLE, starve_cnt = 0.
- if_ack = d_ack = 0; if_data = d_rdata = 0.
- mem_a = 0, mem_wr = 0, mem_dout = 0.
REQ-023 rst mid-transaction SHALL abandon the transaction with no ack. Remaining write bytes SHALL NOT be issued.

Verification
REQ-024 IF word read from 0x100, RAM[0x100..0x103] = 13,00,00,00 -> mem_a 0x100..0x103 in cycles G+1..G+4; if_ack in G+6 with if_data = 0x00000013.
REQ-025 Data half write, d_addr 0x20, d_wdata 0xAABBCCDD -> 0xDD@0x20 (G+1), 0xCC@0x21 (G+2); d_ack in G+3; no third write.
REQ-026 if_req and d_req held continuously (d_req re-raised after each ack) -> grants D,D,D,D,IF,D; starve_cnt clears after the IF grant.
REQ-027 flush pulsed in cycle G+2 of an IF read -> 4 bytes read, no if_ack. A pending d_req is granted in the cycle after DONE.
REQ-028 Byte read at 0xFFFFFFFF, then word read at 0xFFFFFFFE -> second read addresses FFFFFFFE, FFFFFFFF, 0, 1. rdy_in low for 3 cycles mid-read -> data unchanged, ack delayed by 3 cycles.
REQ-029 rst asserted in cycle G+2 of a word write -> exactly 2 bytes written, no d_ack, all outputs 0 next cycle.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one byte-wide RAM between an instruction fetch port and a data port, with starvation-bounded data priority.
module ram_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        flush,
  output logic        if_ack,
  output logic [31:0] if_data,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  localparam int SW = $clog2(STARVE_MAX + 1);
  state_t state;
  logic [SW-1:0] starve_cnt;
  logic [31:0] addr, wdata, rbuf, nbuf, wsh;
  logic [2:0] n, iss, cap;
  logic own_if, flushed, p1, p2, d_win, i_win, rd_done, d_wr;
  always_comb begin
    d_win = d_req && (starve_cnt < SW'(STARVE_MAX) || !if_req);
    i_win = !d_win && if_req && !flush;
    d_wr = d_win && d_we;
    nbuf = p2 ? rbuf | ({24'b0, mem_din} << {cap[1:0], 3'b000}) : rbuf;
    wsh = wdata >> {iss[1:0], 3'b000};
    rd_done = cap == n || (p2 && cap == n - 3'd1);
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      starve_cnt <= '0;
      if_ack <= 1'b0;
      d_ack <= 1'b0;
      if_data <= '0;
      d_rdata <= '0;
      mem_a <= '0;
      mem_wr <= 1'b0;
      mem_dout <= '0;
      addr <= '0;
      wdata <= '0;
      rbuf <= '0;
      n <= '0;
      iss <= '0;
      cap <= '0;
      own_if <= 1'b0;
      flushed <= 1'b0;
      p1 <= 1'b0;
      p2 <= 1'b0;
    end else begin
      case (state)
        IDLE: if (rdy_in && (d_win || i_win)) begin
          state <= d_wr ? WR : RD;
          addr <= d_win ? d_addr : if_addr;
          n <= !d_win ? 3'd4 : d_size == 2'd0 ? 3'd1 : d_size == 2'd1 ? 3'd2 : 3'd4;
          wdata <= d_wdata;
          own_if <= !d_win;
          flushed <= 1'b0;
          iss <= 3'd1;
          cap <= '0;
          rbuf <= '0;
          p1 <= !d_wr;
          p2 <= 1'b0;
          mem_a <= d_win ? d_addr : if_addr;
          mem_wr <= d_wr;
          mem_dout <= d_wr ? d_wdata[7:0] : 8'h00;
          if (i_win) starve_cnt <= '0;
          else if (if_req && starve_cnt < SW'(STARVE_MAX)) starve_cnt <= starve_cnt + SW'(1);
        end
        RD: begin
          // p1: a fresh address is on the bus this cycle; p2: its byte is on mem_din
          p2 <= p1;
          rbuf <= nbuf;
          if (p2) cap <= cap + 3'd1;
          if (own_if && flush) flushed <= 1'b1;
          if (!rdy_in) p1 <= 1'b0;
          else if (rd_done) begin
            state <= DONE;
            p1 <= 1'b0;
            mem_a <= '0;
            if_ack <= own_if && !(flushed || flush);
            if_data <= own_if && !(flushed || flush) ? nbuf : '0;
            d_ack <= !own_if;
            d_rdata <= own_if ? '0 : nbuf;
          end else if (iss < n) begin
            mem_a <= addr + {29'b0, iss};
            iss <= iss + 3'd1;
            p1 <= 1'b1;
          end else begin
            mem_a <= '0;
            p1 <= 1'b0;
          end
        end
        WR: begin
          // a byte only counts as written in a cycle where rdy_in was high; after a stall it is re-driven
          if (!rdy_in) mem_wr <= 1'b0;
          else if (!mem_wr) mem_wr <= 1'b1;
          else if (iss < n) begin
            mem_a <= addr + {29'b0, iss};
            mem_dout <= wsh[7:0];
            iss <= iss + 3'd1;
          end else begin
            state <= DONE;
            mem_a <= '0;
            mem_dout <= '0;
            mem_wr <= 1'b0;
            d_ack <= 1'b1;
            d_rdata <= '0;
          end
        end
        default: begin
          state <= IDLE;
          if_ack <= 1'b0;
          d_ack <= 1'b0;
          if_data <= '0;
          d_rdata <= '0;
        end
      endcase
    end
  end
endmodule
